wb_line_cache: RTL and testbench
================================

Name: wb_line_cache

Overview:
- Direct-mapped, write-back L1 line cache; the wishbone responder for the datapath's `ifetch` or `memory` master port.
- Serves 128-bit line reads and byte-selected line writes to the CPU side.
- On a miss it acts as wishbone initiator toward physical memory: it writes back a dirty victim, then fills the line.
- One instance sits on each CPU port (I-side and D-side); an arbiter downstream merges their pmem ports.

Parameters:
- INDEX_BITS, 3, log2 of number of sets (default 8 lines).
- TAG_BITS, 12-INDEX_BITS, derived; CPU line address is 12 bits (address bits 15:4).

Ports:
- clk  in  1  system clock (CLK of both wishbone bundles)
- rst  in  1  synchronous, active-high reset
- cpu_adr  in  12  line address from CPU master
- cpu_dat_m  in  128  write line from CPU
- cpu_sel  in  16  byte enables, bit i covers byte i of the line
- cpu_we  in  1  write request
- cpu_stb  in  1  strobe
- cpu_cyc  in  1  cycle valid
- cpu_dat_s  out  128  read line to CPU
- cpu_ack  out  1  transfer complete
- pmem_adr  out  12  line address to physical memory
- pmem_dat_m  out  128  victim line
- pmem_sel  out  16  always 16'hFFFF when pmem_stb is high
- pmem_we  out  1  pmem write
- pmem_stb  out  1  pmem strobe
- pmem_cyc  out  1  pmem cycle
- pmem_dat_s  in  128  fill line
- pmem_ack  in  1  pmem transfer complete

Behaviour:
- Address split: index = cpu_adr[INDEX_BITS-1:0], tag = cpu_adr[11:INDEX_BITS].
- Storage per set: valid, dirty, tag, 128-bit data. All are flops, so reads are combinational.
- States: IDLE, WRITEBACK, ALLOCATE.
- Reset:
  - All valid and dirty bits cleared; state returns to IDLE.
  - cpu_ack=0, pmem_stb=pmem_cyc=pmem_we=0, pmem_sel=0.
  - Data and tag contents are don't-care.
  - Reset asserted mid-WRITEBACK or mid-ALLOCATE abandons the pmem transfer; pmem_stb is low the cycle after the reset edge.
- IDLE:
  - hit = cpu_cyc & cpu_stb & valid[index] & (tag[index]==tag).
  - On a hit, cpu_ack=1 combinationally in the same cycle (zero-wait-state hit).
  - Read hit: cpu_dat_s = data[index].
  - Write hit: at the clock edge, each byte i with cpu_sel[i]=1 takes cpu_dat_m byte i; dirty[index] is set.
  - Every cycle with stb and a hit is one transfer. A held strobe on the same address re-acks each cycle; a write repeated this way is idempotent.
  - Miss: latch cpu_adr into miss_adr. Go to WRITEBACK if valid&dirty[index], else go to ALLOCATE. cpu_ack=0.
  - cpu_stb=0 or cpu_cyc=0: cpu_ack=0, no state change.
- WRITEBACK:
  - Drives pmem_adr={tag[idx], idx}, pmem_dat_m=data[idx], pmem_we=1, pmem_stb=pmem_cyc=1, where idx=miss_adr index.
  - Held until pmem_ack. On pmem_ack: dirty[idx] cleared, go to ALLOCATE.
- ALLOCATE:
  - Drives pmem_adr=miss_adr, pmem_we=0, pmem_stb=pmem_cyc=1.
  - On pmem_ack: data[idx]=pmem_dat_s, tag written, valid=1, dirty=0, go to IDLE.
- After a miss, IDLE re-evaluates the current CPU request and hits on the next cycle. Miss latency is (1 if dirty) pmem round trips + 1 pmem round trip + 1 cycle.
- cpu_ack is never asserted outside IDLE.
- CPU address changes or cpu_cyc drops during a miss: the fill still completes using miss_adr.
- pmem_ack while not in WRITEBACK/ALLOCATE is ignored.
- cpu_dat_s outside a read hit is don't-care; it is driven from data[index] to avoid a mux.

Decomposition:
- lc3b_types gains:
  - a wb_cache_state_t enum {IDLE, WRITEBACK, ALLOCATE};
  - the constant LINE_ADDR_BITS=12;
  - reuses the existing lc3b_line (128-bit).
- One natural sub-module, cache_line_array:
  - contains the valid/dirty/tag/data flops with a combinational read port;
  - has a write port with 16-bit byte mask plus a separate full-line fill port;
  - has set_dirty and clr_dirty controls.
- Top level holds the FSM, the miss_adr register and the output muxing.

Test Plan:
- Reset, then read 12'h010 (index 0, clean miss) → ALLOCATE; pmem_adr=12'h010, pmem_we=0. Return pmem_dat_s=128'hA5..A5 after 3 cycles → next cycle cpu_ack=1, cpu_dat_s=128'hA5..A5.
- Write hit 12'h010, cpu_sel=16'h0003, cpu_dat_m low halfword=16'hBEEF → same-cycle cpu_ack. A following read returns low halfword 16'hBEEF, upper bytes still A5.
- Read 12'h018 (same index, different tag) while 12'h010 is dirty → WRITEBACK with pmem_adr=12'h010, pmem_we=1, pmem_dat_m holding BEEF. Then ALLOCATE at 12'h018; no cpu_ack until the fill completes.
- Change cpu_adr and drop cpu_cyc mid-ALLOCATE → fill completes into the latched line. Re-request the original address → hit with zero pmem traffic.
- Assert rst during WRITEBACK → pmem_stb=0 the next cycle, state IDLE. A read of any prior address misses, because valid was cleared.
- Hold cpu_stb=1 on a hitting address for 4 cycles → cpu_ack high all 4 cycles, pmem_stb stays 0.

Source files
------------

// File: rtl/wb_line_cache_pkg.sv
// Shared types for the write-back line cache: line type, FSM state and line address width.
package wb_line_cache_pkg;
  localparam int LINE_ADDR_BITS = 12;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } wb_cache_state_t;
endpackage

// File: rtl/wb_line_cache_array.sv
// Flop-based set storage (valid/dirty/tag/data) with a combinational read port,
// a byte-masked CPU write port and a full-line fill port, all at one index.
module wb_line_cache_array
  import wb_line_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = LINE_ADDR_BITS - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output lc3b_line              rd_data,
  input  logic                  wr_en,
  input  logic [15:0]           wr_mask,
  input  lc3b_line              wr_data,
  input  logic                  fill_en,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  lc3b_line              fill_data,
  input  logic                  set_dirty,
  input  logic                  clr_dirty
);
  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  lc3b_line            data_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else begin
      if (set_dirty) dirty_q[idx] <= 1'b1;
      if (clr_dirty) dirty_q[idx] <= 1'b0;
    end
  end

  // Tag and data carry no reset; a cleared valid bit makes them unobservable.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= fill_data;
      tag_q[idx]  <= fill_tag;
    end else if (wr_en) begin
      for (int i = 0; i < 16; i++) begin
        if (wr_mask[i]) data_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/wb_line_cache.sv
// Direct-mapped write-back L1 line cache: zero-wait-state hits toward the CPU,
// dirty-victim writeback followed by line fill toward physical memory on a miss.
module wb_line_cache
  import wb_line_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = LINE_ADDR_BITS - INDEX_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LINE_ADDR_BITS-1:0] cpu_adr,
  input  lc3b_line                  cpu_dat_m,
  input  logic [15:0]               cpu_sel,
  input  logic                      cpu_we,
  input  logic                      cpu_stb,
  input  logic                      cpu_cyc,
  output lc3b_line                  cpu_dat_s,
  output logic                      cpu_ack,
  output logic [LINE_ADDR_BITS-1:0] pmem_adr,
  output lc3b_line                  pmem_dat_m,
  output logic [15:0]               pmem_sel,
  output logic                      pmem_we,
  output logic                      pmem_stb,
  output logic                      pmem_cyc,
  input  lc3b_line                  pmem_dat_s,
  input  logic                      pmem_ack
);
  wb_cache_state_t state_q, state_d;
  logic [LINE_ADDR_BITS-1:0] miss_adr_q;

  logic [INDEX_BITS-1:0] cpu_idx, miss_idx, arr_idx;
  logic [TAG_BITS-1:0]   cpu_tag, miss_tag, rd_tag;
  logic                  rd_valid, rd_dirty;
  lc3b_line              rd_data;
  logic                  req, hit;
  logic                  wr_en, set_dirty, clr_dirty, fill_en;

  assign cpu_idx  = cpu_adr[INDEX_BITS-1:0];
  assign cpu_tag  = cpu_adr[LINE_ADDR_BITS-1:INDEX_BITS];
  assign miss_idx = miss_adr_q[INDEX_BITS-1:0];
  assign miss_tag = miss_adr_q[LINE_ADDR_BITS-1:INDEX_BITS];

  // One array port serves both sides: CPU index while idle, latched miss index otherwise.
  assign arr_idx = (state_q == IDLE) ? cpu_idx : miss_idx;

  assign req = cpu_cyc & cpu_stb;
  assign hit = req & rd_valid & (rd_tag == cpu_tag);

  assign cpu_dat_s  = rd_data;
  assign pmem_dat_m = rd_data;

  wb_line_cache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (arr_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_mask  (cpu_sel),
    .wr_data  (cpu_dat_m),
    .fill_en  (fill_en),
    .fill_tag (miss_tag),
    .fill_data(pmem_dat_s),
    .set_dirty(set_dirty),
    .clr_dirty(clr_dirty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req && !hit) miss_adr_q <= cpu_adr;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (pmem_ack) state_d = ALLOCATE;
      ALLOCATE:  if (pmem_ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are held quiet while rst is high so a reset edge never sees a stray ack or write.
  always_comb begin
    cpu_ack   = 1'b0;
    wr_en     = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    fill_en   = 1'b0;
    pmem_adr  = miss_adr_q;
    pmem_we   = 1'b0;
    pmem_stb  = 1'b0;
    pmem_cyc  = 1'b0;
    pmem_sel  = 16'h0000;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            cpu_ack   = 1'b1;
            wr_en     = cpu_we;
            set_dirty = cpu_we;
          end
        end
        WRITEBACK: begin
          pmem_adr  = {rd_tag, miss_idx};
          pmem_we   = 1'b1;
          pmem_stb  = 1'b1;
          pmem_cyc  = 1'b1;
          pmem_sel  = 16'hFFFF;
          clr_dirty = pmem_ack;
        end
        ALLOCATE: begin
          pmem_stb = 1'b1;
          pmem_cyc = 1'b1;
          pmem_sel = 16'hFFFF;
          fill_en  = pmem_ack;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_line_cache.sv
// Directed bench for wb_line_cache: bench drives both the CPU and pmem sides by hand.
module tb_wb_line_cache;
  logic         clk;
  logic         rst;
  logic [11:0]  cpu_adr;
  logic [127:0] cpu_dat_m;
  logic [15:0]  cpu_sel;
  logic         cpu_we, cpu_stb, cpu_cyc;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack;
  logic [11:0]  pmem_adr;
  logic [127:0] pmem_dat_m;
  logic [15:0]  pmem_sel;
  logic         pmem_we, pmem_stb, pmem_cyc;
  logic [127:0] pmem_dat_s;
  logic         pmem_ack;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_A5   = {16{8'hA5}};
  localparam logic [127:0] LINE_5A   = {16{8'h5A}};
  localparam logic [127:0] LINE_BEEF = {{14{8'hA5}}, 16'hBEEF};
  localparam logic [127:0] LINE_11   = {16{8'h11}};

  wb_line_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_adr   (cpu_adr),
    .cpu_dat_m (cpu_dat_m),
    .cpu_sel   (cpu_sel),
    .cpu_we    (cpu_we),
    .cpu_stb   (cpu_stb),
    .cpu_cyc   (cpu_cyc),
    .cpu_dat_s (cpu_dat_s),
    .cpu_ack   (cpu_ack),
    .pmem_adr  (pmem_adr),
    .pmem_dat_m(pmem_dat_m),
    .pmem_sel  (pmem_sel),
    .pmem_we   (pmem_we),
    .pmem_stb  (pmem_stb),
    .pmem_cyc  (pmem_cyc),
    .pmem_dat_s(pmem_dat_s),
    .pmem_ack  (pmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic [11:0] adr, input logic we,
                         input logic [15:0] sel, input logic [127:0] dat);
    cpu_adr   = adr;
    cpu_we    = we;
    cpu_sel   = sel;
    cpu_dat_m = dat;
    cpu_stb   = 1'b1;
    cpu_cyc   = 1'b1;
  endtask

  task automatic pmem_pulse(input logic [127:0] dat);
    pmem_dat_s = dat;
    pmem_ack   = 1'b1;
    tick();
    pmem_ack   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_adr = '0; cpu_dat_m = '0; cpu_sel = '0;
    cpu_we = 1'b0; cpu_stb = 1'b0; cpu_cyc = 1'b0;
    pmem_dat_s = '0; pmem_ack = 1'b0;
    tick(); tick();
    #1;
    check("rst_cpu_ack", 128'(cpu_ack), 128'd0);
    check("rst_pmem_stb", 128'(pmem_stb), 128'd0);
    check("rst_pmem_cyc", 128'(pmem_cyc), 128'd0);
    check("rst_pmem_we", 128'(pmem_we), 128'd0);
    check("rst_pmem_sel", 128'(pmem_sel), 128'd0);
    rst = 1'b0;
    tick();

    // Clean miss on 0x010, fill returned after three ALLOCATE cycles.
    cpu_req(12'h010, 1'b0, 16'h0000, '0);
    #1;
    check("miss_no_ack", 128'(cpu_ack), 128'd0);
    tick(); #1;
    check("alloc_stb", 128'(pmem_stb), 128'd1);
    check("alloc_cyc", 128'(pmem_cyc), 128'd1);
    check("alloc_we", 128'(pmem_we), 128'd0);
    check("alloc_adr", 128'(pmem_adr), 128'h010);
    check("alloc_sel", 128'(pmem_sel), 128'hFFFF);
    check("alloc_no_ack", 128'(cpu_ack), 128'd0);
    tick(); tick();
    check("alloc_held", 128'(pmem_stb), 128'd1);
    pmem_pulse(LINE_A5);
    #1;
    check("fill_ack", 128'(cpu_ack), 128'd1);
    check("fill_data", cpu_dat_s, LINE_A5);
    check("fill_stb_low", 128'(pmem_stb), 128'd0);

    // Byte-masked write hit, acked in the same cycle.
    cpu_req(12'h010, 1'b1, 16'h0003, {112'h0, 16'hBEEF});
    #1;
    check("wr_hit_ack", 128'(cpu_ack), 128'd1);
    tick();
    cpu_req(12'h010, 1'b0, 16'h0000, '0);
    #1;
    check("rd_after_wr", cpu_dat_s, LINE_BEEF);
    check("rd_after_wr_ack", 128'(cpu_ack), 128'd1);

    // Conflict miss on 0x018 evicts dirty 0x010.
    cpu_req(12'h018, 1'b0, 16'h0000, '0);
    #1;
    check("conf_no_ack", 128'(cpu_ack), 128'd0);
    tick(); #1;
    check("wb_stb", 128'(pmem_stb), 128'd1);
    check("wb_we", 128'(pmem_we), 128'd1);
    check("wb_adr", 128'(pmem_adr), 128'h010);
    check("wb_dat", pmem_dat_m, LINE_BEEF);
    check("wb_no_ack", 128'(cpu_ack), 128'd0);
    pmem_pulse('0);
    #1;
    check("alloc2_we", 128'(pmem_we), 128'd0);
    check("alloc2_adr", 128'(pmem_adr), 128'h018);
    check("alloc2_no_ack", 128'(cpu_ack), 128'd0);

    // CPU wanders off mid-fill; the line still lands at 0x018.
    cpu_adr = 12'h123; cpu_cyc = 1'b0; cpu_stb = 1'b0;
    tick(); #1;
    check("alloc2_adr_kept", 128'(pmem_adr), 128'h018);
    pmem_pulse(LINE_5A);
    #1;
    check("idle_no_req_ack", 128'(cpu_ack), 128'd0);
    check("idle_stb", 128'(pmem_stb), 128'd0);
    cpu_req(12'h018, 1'b0, 16'h0000, '0);
    #1;
    check("rereq_hit", 128'(cpu_ack), 128'd1);
    check("rereq_data", cpu_dat_s, LINE_5A);

    // Stray pmem_ack while idle must not disturb anything.
    pmem_ack = 1'b1;
    tick();
    pmem_ack = 1'b0;
    #1;
    check("stray_ack_stb", 128'(pmem_stb), 128'd0);

    // Held strobe re-acks every cycle with no pmem traffic.
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hold_ack%0d", i), 128'(cpu_ack), 128'd1);
      check($sformatf("hold_stb%0d", i), 128'(pmem_stb), 128'd0);
      tick();
    end

    // Dirty 0x018, then miss on 0x010 and reset mid-WRITEBACK.
    cpu_req(12'h018, 1'b1, 16'hFFFF, LINE_11);
    tick();
    cpu_req(12'h010, 1'b0, 16'h0000, '0);
    tick(); #1;
    check("wb2_we", 128'(pmem_we), 128'd1);
    check("wb2_adr", 128'(pmem_adr), 128'h018);
    check("wb2_dat", pmem_dat_m, LINE_11);
    rst = 1'b1;
    tick();
    check("rst_wb_stb", 128'(pmem_stb), 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_stb", 128'(pmem_stb), 128'd0);
    cpu_req(12'h018, 1'b0, 16'h0000, '0);
    #1;
    check("post_rst_miss", 128'(cpu_ack), 128'd0);
    tick(); #1;
    check("post_rst_alloc_we", 128'(pmem_we), 128'd0);
    check("post_rst_alloc_adr", 128'(pmem_adr), 128'h018);
    check("post_rst_alloc_stb", 128'(pmem_stb), 128'd1);
    pmem_pulse(LINE_A5);
    #1;
    check("post_rst_hit", 128'(cpu_ack), 128'd1);
    check("post_rst_data", cpu_dat_s, LINE_A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
